// File: rtl/flag_unit_pkg.sv
// rtl/flag_unit_pkg.sv - NZCV flag type and bit positions shared with the condition evaluator
package flag_unit_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/flag_calc.sv
// rtl/flag_calc.sv - combinational NZCV derivation from one ALU result
module flag_calc
    import flag_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             ex_logical,
    output flags_t           flags
);

    // Logical ops architecturally clear C and V rather than passing the adder outputs.
    always_comb begin
        flags   = FLAGS_RESET;
        flags.n = alu_result[WIDTH-1];
        flags.z = (alu_result == '0);
        flags.c = ex_logical ? 1'b0 : alu_carry;
        flags.v = ex_logical ? 1'b0 : alu_overflow;
    end

endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - pending/architectural NZCV registers with in-flight bypass
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic             ex_cond_met,
    input  logic             ex_logical,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic [3:0]       flags,
    output logic [3:0]       arch_flags,
    output logic             pending_valid
);

    flags_t calc_flags;
    flags_t pending_flags_q, pending_flags_d;
    flags_t arch_flags_q, arch_flags_d;
    logic   pending_valid_q, pending_valid_d;
    logic   capture;

    flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .ex_logical   (ex_logical),
        .flags        (calc_flags)
    );

    assign capture = ex_valid & ex_set_flags & ex_cond_met & ~flush & ~stall;

    // Flush only blocks a new capture; an update already pending still commits.
    always_comb begin
        pending_flags_d = pending_flags_q;
        pending_valid_d = pending_valid_q;
        arch_flags_d    = arch_flags_q;
        if (!stall) begin
            pending_valid_d = capture;
            if (capture) begin
                pending_flags_d = calc_flags;
            end
            if (pending_valid_q) begin
                arch_flags_d = pending_flags_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_flags_q <= FLAGS_RESET;
            pending_valid_q <= 1'b0;
            arch_flags_q    <= FLAGS_RESET;
        end else begin
            pending_flags_q <= pending_flags_d;
            pending_valid_q <= pending_valid_d;
            arch_flags_q    <= arch_flags_d;
        end
    end

    // Bypass is register-only so the condition evaluator sees no ALU-to-flags path.
    assign flags         = pending_valid_q ? pending_flags_q : arch_flags_q;
    assign arch_flags    = arch_flags_q;
    assign pending_valid = pending_valid_q;

endmodule

// File: doc/flag_unit.md
# flag_unit

Producer side of the NZCV condition flags: computes flags from EX-stage ALU results, stages them one cycle in a pending register, and commits them to the architectural flags register. It drives the flags vector consumed by the condition evaluator, with in-flight pending flags bypassed ahead of the committed value. It sits beside the ALU in the pipelined datapath, under the hazard unit's stall/flush control.

## Interface
Parameters:
- WIDTH, 64, ALU result width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all state this cycle.
- flush  in  1  kill the EX-stage instruction; blocks capture.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_set_flags  in  1  EX instruction is a flag-setting op (S variant).
- ex_cond_met  in  1  EX instruction's condition passed.
- ex_logical  in  1  1 = logical op (ANDS etc.), 0 = arithmetic (ADDS/SUBS).
- alu_result  in  WIDTH  ALU result.
- alu_carry  in  1  ALU carry out.
- alu_overflow  in  1  ALU signed overflow.
- flags  out  4  forwarded flags for condition evaluation, {N,Z,C,V} in bits [3:0].
- arch_flags  out  4  committed flags register.
- pending_valid  out  1  a flag update is in flight.

## Operation
- Flag computation (combinational, from EX inputs): N = alu_result[WIDTH-1]; Z = (alu_result == 0); arithmetic: C = alu_carry, V = alu_overflow; logical: C = 0, V = 0.
- capture = ex_valid & ex_set_flags & ex_cond_met & ~flush & ~stall.
- On a non-stalled cycle:
  - pending_flags <= computed flags when capture; otherwise unchanged.
  - pending_valid <= capture.
  - arch_flags <= pending_flags if pending_valid was 1; otherwise unchanged.
- Stalled cycle: pending_flags, pending_valid and arch_flags all hold. Flush does not affect an already-pending update; it commits normally.
- Flush and stall together: stall wins for pending/arch (hold); no capture.
- flags = pending_valid ? pending_flags : arch_flags. Driven purely from registers, with no combinational path from ALU inputs.
- Back-to-back captures: each pending value commits the following cycle while the next capture replaces it. No update is ever lost or reordered.

## Timing
- Reset: arch_flags = 4'b0000, pending_flags = 4'b0000, pending_valid = 0, flags = 4'b0000.
- Reset mid-operation discards any pending update; arch_flags returns to 0000 the cycle after reset is sampled.
- Capture at edge T: flags shows the new value from T, with pending_valid = 1. arch_flags shows the new value from T+1 (if T+1 is not stalled).
- Latency from ALU inputs to flags: 1 cycle. Latency from ALU inputs to arch_flags: 2 cycles, plus any stall cycles.
- A consumer reading flags in the cycle after a capture sees the newest value (the bypass). No stall is required for a dependent conditional instruction.

## Structure
- Shared package: flags_t (4-bit packed {n,z,c,v}), bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0. The condition evaluator uses the same constants.
- One sub-module, flag_calc: purely combinational, WIDTH-parameterised. Inputs are alu_result, alu_carry, alu_overflow and ex_logical; output is flags_t.
- flag_unit itself holds only the pending/arch registers, the capture logic and the bypass mux.

## Test plan
- Reset held 2 cycles with random ALU inputs and ex_valid=1 → flags=0000, arch_flags=0000, pending_valid=0.
- Arithmetic op, result=0, carry=1, overflow=0, all enables 1 → next cycle flags=0110, pending_valid=1, arch_flags=0000; cycle after that arch_flags=0110, pending_valid=0.
- Back-to-back captures: result=0x8000_0000_0000_0000 with V=1, then result=5 with C=1 → flags=1001 then 0010 on consecutive cycles; arch_flags lags one cycle; both values appear in order.
- ex_cond_met=0 (or ex_set_flags=0, or ex_valid=0) with result=0 → flags and arch_flags unchanged, pending_valid=0.
- Capture, then stall for 3 cycles → pending_valid stays 1, flags holds the new value, arch_flags unchanged; on stall release arch_flags updates the next cycle.
- Logical op, result=0xFFFF_FFFF_FFFF_FFFF, carry=1, overflow=1 → flags=1000. Then the same stimulus with flush=1 → no capture, flags unchanged.
